multi_queue_output_arbiter: RTL and testbench
=============================================

# multi_queue_output_arbiter

Merges the `QUEUE_COUNT` per-queue output streams of `multi_queue_fifo_reader` onto one shared output link. Arbitration is round-robin and packet-atomic: once a queue wins, it keeps the link until its `last` beat has transferred. The block is the stage directly downstream of the reader. Its registered output feeds the port transmitter.

## Interface
- `QUEUE_COUNT`, 4: number of input queues; must be ≥1.
- `DATA_WIDTH`, 32: payload width per beat.
- `QID_WIDTH`, max(1, $clog2(QUEUE_COUNT)): width of the queue identifier.

Ports:
- `clk`  in  1  clock. One clock domain; every register is clocked on its rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `in_valid`  in  QUEUE_COUNT  per-queue beat valid.
- `in_ready`  out  QUEUE_COUNT  per-queue beat accept.
- `in_data`  in  QUEUE_COUNT×DATA_WIDTH  per-queue beat payload.
- `in_last`  in  QUEUE_COUNT  marks the final beat of a packet.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_WIDTH  output payload.
- `out_last`  out  1  final beat of the output packet.
- `out_queue`  out  QID_WIDTH  source queue of the current output beat.

## Operation
- Input transfer on queue i: `in_valid[i] && in_ready[i]` at a rising edge. Output transfer: `out_valid && out_ready`.
- Output stage: one pipeline register holding data, last, queue and valid. The register is free when `!out_valid || out_ready`.
- `in_ready[i] = slot_free && (i == sel)`. At most one `in_ready` bit is high in any cycle (onehot0). This invariant is mandatory.
- State machine, two states:
  - **IDLE**: `sel` is the first queue with `in_valid` set, searching cyclically from `rr_ptr`. If no queue is valid, `in_ready` is all zero.
  - IDLE, on a transfer from `sel` with `in_last=0`: `grant <= sel`, go to LOCKED.
  - IDLE, on a transfer with `in_last=1` (single-beat packet): stay in IDLE, `rr_ptr <= (sel+1) mod QUEUE_COUNT`.
  - **LOCKED**: `sel = grant`, regardless of the other queues' valids.
  - LOCKED, on a transfer with `in_last=1`: go to IDLE, `rr_ptr <= (grant+1) mod QUEUE_COUNT`.
- Round-robin pointer wraps from `QUEUE_COUNT-1` to 0. With `QUEUE_COUNT=1` the pointer is constantly 0.
- The granted queue may drop `in_valid` mid-packet. The lock holds, no beat is emitted (bubble), and other queues are not served until that packet's last beat.
- Beats are never dropped, duplicated or reordered within a queue. Packets from different queues never interleave on the output.

## Timing
- Latency: a beat accepted at edge N appears on `out_*` in the cycle after edge N (1 cycle).
- Throughput: one beat per cycle while `out_ready=1`, including back-to-back packets from different queues (no dead cycle at a grant switch).
- `in_ready` depends combinationally on `in_valid`, `out_ready` and state. `out_*` comes purely from registers.
- The output register is updated only on an input transfer or an output transfer. While `out_valid && !out_ready`, the output is held stable.
- Reset, when `rst_n=0` at an edge:
  - `out_valid`, `out_last` become 0; `out_data` becomes 0; `out_queue` becomes 0.
  - State goes to IDLE and `rr_ptr` to 0.
  - `in_ready` is all zero during any cycle with `rst_n=0`.
- Reset mid-packet discards the lock and any held beat. The remainder of the packet is then arbitrated as a new packet; resynchronising after reset is the upstream's responsibility.

## Test plan
- Single-beat packet `A0=0x11` (last=1) on queue 2 only, with `out_ready=1`:
  - `in_ready=4'b0100` in the same cycle.
  - The next cycle shows `out_valid=1`, `out_data=0x11`, `out_last=1`, `out_queue=2`.
  - `rr_ptr` becomes 3.
- All 4 queues continuously offer single-beat packets from reset, `out_ready=1`:
  - Output queue order is 0,1,2,3,0,1…
  - One beat per cycle, with no bubbles.
- Queue 0 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last) while queue 1 is valid throughout:
  - Output is 0xA0, 0xA1, 0xA2 from q0, then q1's beat.
  - `in_ready[1]` stays 0 until q0's last beat has transferred.
- Backpressure: `out_ready=0` for 5 cycles with a beat held:
  - `out_*` stays stable and `in_ready` stays all zero.
  - After `out_ready=1`, the pending beat follows with no loss.
- Mid-packet gap: q3 sends 2 beats, drops `in_valid` for 3 cycles, then sends its last beat; q0 is valid throughout.
  - q0 is not served until q3's last beat.
  - The output shows a 3-cycle gap.
- `rst_n=0` for one cycle during beat 2 of a 4-beat q1 packet:
  - The next cycle has `out_valid=0` and state IDLE.
  - A subsequent valid q0 beat wins, since `rr_ptr=0`.

Source files
------------

// File: rtl/multi_queue_output_arbiter_if.sv
// Handshake bundle between the per-queue reader streams, the arbiter and the shared output link.
// The master modport is the arbiter side; the slave modport is the surrounding environment.
interface multi_queue_output_arbiter_if #(
  parameter int unsigned QUEUE_COUNT = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned QID_WIDTH   = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1
);
  logic [QUEUE_COUNT-1:0]                 in_valid;
  logic [QUEUE_COUNT-1:0]                 in_ready;
  logic [QUEUE_COUNT-1:0][DATA_WIDTH-1:0] in_data;
  logic [QUEUE_COUNT-1:0]                 in_last;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [DATA_WIDTH-1:0]                  out_data;
  logic                                   out_last;
  logic [QID_WIDTH-1:0]                   out_queue;

  modport master (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_queue
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_queue
  );
endinterface

// File: rtl/multi_queue_output_arbiter.sv
// Packet-atomic round-robin merge of QUEUE_COUNT reader streams onto one registered output link.
// A queue that wins keeps the link until its last beat transfers; no dead cycle at grant switches.
module multi_queue_output_arbiter #(
  parameter int unsigned QUEUE_COUNT = 4,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multi_queue_output_arbiter_if.master bus
);
  localparam int unsigned QID_WIDTH = (QUEUE_COUNT > 1) ? $clog2(QUEUE_COUNT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                                state_q, state_d;
  logic [QID_WIDTH-1:0]                  grant_q, grant_d;
  logic [QID_WIDTH-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [QUEUE_COUNT-1:0][QID_WIDTH-1:0] scan_idx;
  logic [QID_WIDTH-1:0]                  scan_sel;
  logic                                  scan_found;
  logic [QID_WIDTH-1:0]                  sel;
  logic                                  sel_valid;
  logic                                  slot_free;
  logic                                  in_xfer;
  logic                                  sel_last;
  logic [QUEUE_COUNT-1:0]                in_ready_c;

  logic                                  out_valid_q;
  logic                                  out_last_q;
  logic [DATA_WIDTH-1:0]                 out_data_q;
  logic [QID_WIDTH-1:0]                  out_queue_q;

  function automatic logic [QID_WIDTH-1:0] wrap_inc(input logic [QID_WIDTH-1:0] q);
    return QID_WIDTH'((32'(q) + 32'd1) % QUEUE_COUNT);
  endfunction

  // Candidate queue order for the cyclic search, starting at the round-robin pointer
  for (genvar k = 0; k < QUEUE_COUNT; k++) begin : g_scan_idx
    assign scan_idx[k] = QID_WIDTH'((32'(rr_ptr_q) + 32'(k)) % QUEUE_COUNT);
  end

  always_comb begin
    scan_found = 1'b0;
    scan_sel   = rr_ptr_q;
    for (int unsigned k = 0; k < QUEUE_COUNT; k++) begin
      if (!scan_found && bus.in_valid[scan_idx[k]]) begin
        scan_found = 1'b1;
        scan_sel   = scan_idx[k];
      end
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready;

  // Next-state, selection and per-queue ready; ready is onehot0 by construction
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    sel        = scan_sel;
    sel_valid  = scan_found;
    in_ready_c = '0;

    if (state_q == LOCKED) begin
      sel       = grant_q;
      sel_valid = 1'b1;
    end

    if (rst_n && slot_free && sel_valid) begin
      in_ready_c[sel] = 1'b1;
    end

    in_xfer  = bus.in_valid[sel] && in_ready_c[sel];
    sel_last = bus.in_last[sel];

    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          if (sel_last) begin
            rr_ptr_d = wrap_inc(sel);
          end else begin
            grant_d = sel;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (in_xfer && sel_last) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(grant_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output pipeline register: loads on an input transfer, empties on a bare output transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_queue_q <= '0;
    end else if (in_xfer) begin
      out_valid_q <= 1'b1;
      out_last_q  <= sel_last;
      out_data_q  <= bus.in_data[sel];
      out_queue_q <= sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_queue = out_queue_q;
endmodule

// File: tb/tb_multi_queue_output_arbiter.sv
// Directed bench for multi_queue_output_arbiter: reset, arbitration order, packet lock,
// backpressure, mid-packet gaps and reset in the middle of a packet.
module tb_multi_queue_output_arbiter;
  localparam int unsigned QC = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned QW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  multi_queue_output_arbiter_if #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW), .QID_WIDTH(QW)) bus ();

  multi_queue_output_arbiter #(.QUEUE_COUNT(QC), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 4'hF;
    bus.in_last   = 4'hF;
    bus.in_data   = '1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_queue !== 2'd0) begin fails++; $display("FAIL reset_out_queue got=%0d exp=0", bus.out_queue); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL reset_rr_ptr got=%0d exp=0", dut.rr_ptr_q); end
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic test_single_beat();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 32'h11;
    bus.in_last[2] = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin fails++; $display("FAIL single_in_ready got=%b exp=0100", bus.in_ready); end
    tick();
    bus.in_valid = '0;
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h11) begin fails++; $display("FAIL single_out_data got=%h exp=11", bus.out_data); end
    checks++; if (bus.out_last !== 1'b1) begin fails++; $display("FAIL single_out_last got=%b exp=1", bus.out_last); end
    checks++; if (bus.out_queue !== 2'd2) begin fails++; $display("FAIL single_out_queue got=%0d exp=2", bus.out_queue); end
    checks++; if (dut.rr_ptr_q !== 2'd3) begin fails++; $display("FAIL single_rr_ptr got=%0d exp=3", dut.rr_ptr_q); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'hF;
    bus.in_last   = 4'hF;
    for (int i = 0; i < 4; i++) bus.in_data[i] = DW'(32'h100 + i);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid cycle=%0d got=%b exp=1", c, bus.out_valid); end
      checks++; if (bus.out_queue !== QW'(c % 4)) begin fails++; $display("FAIL rr_queue cycle=%0d got=%0d exp=%0d", c, bus.out_queue, c % 4); end
      checks++; if (bus.out_data !== DW'(32'h100 + (c % 4))) begin fails++; $display("FAIL rr_data cycle=%0d got=%h exp=%h", c, bus.out_data, 32'h100 + (c % 4)); end
    end
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_packet_lock();
    do_reset();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0011;
    bus.in_last    = 4'b0010;
    bus.in_data[1] = 32'hB1;
    for (int b = 0; b < 3; b++) begin
      bus.in_data[0] = DW'(32'hA0 + b);
      bus.in_last[0] = (b == 2);
      #1;
      checks++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL lock_in_ready beat=%0d got=%b exp=0001", b, bus.in_ready); end
      tick();
      checks++; if (bus.out_data !== DW'(32'hA0 + b)) begin fails++; $display("FAIL lock_data beat=%0d got=%h exp=%h", b, bus.out_data, 32'hA0 + b); end
      checks++; if (bus.out_queue !== 2'd0) begin fails++; $display("FAIL lock_queue beat=%0d got=%0d exp=0", b, bus.out_queue); end
      checks++; if (bus.out_last !== (b == 2)) begin fails++; $display("FAIL lock_last beat=%0d got=%b exp=%b", b, bus.out_last, b == 2); end
    end
    bus.in_valid = 4'b0010;
    #1;
    checks++; if (bus.in_ready !== 4'b0010) begin fails++; $display("FAIL lock_switch_ready got=%b exp=0010", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 32'hB1 || bus.out_queue !== 2'd1 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL lock_switch_beat got=%h/q%0d/v%b exp=b1/q1/v1", bus.out_data, bus.out_queue, bus.out_valid);
    end
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0100;
    bus.in_last    = 4'hF;
    bus.in_data[2] = 32'h22;
    tick();
    bus.in_data[2] = 32'h23;
    bus.out_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0000", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22 || bus.out_queue !== 2'd2 || bus.out_last !== 1'b1) begin
        fails++; $display("FAIL bp_hold cycle=%0d got=v%b/%h/q%0d/l%b exp=v1/22/q2/l1", i, bus.out_valid, bus.out_data, bus.out_queue, bus.out_last);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got=%b exp=0100", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h23) begin fails++; $display("FAIL bp_pending got=v%b/%h exp=v1/23", bus.out_valid, bus.out_data); end
    bus.in_valid = '0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_mid_packet_gap();
    do_reset();
    bus.out_ready  = 1'b1;
    bus.in_last    = 4'hF;
    bus.in_valid   = 4'b0100;
    bus.in_data[2] = 32'h2F;
    tick();
    bus.in_valid   = 4'b1001;
    bus.in_data[0] = 32'hC0;
    bus.in_data[3] = 32'hD0;
    bus.in_last[3] = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 4'b1000) begin fails++; $display("FAIL gap_first_ready got=%b exp=1000", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 32'hD0 || bus.out_queue !== 2'd3) begin fails++; $display("FAIL gap_beat0 got=%h/q%0d exp=d0/q3", bus.out_data, bus.out_queue); end
    bus.in_data[3] = 32'hD1;
    tick();
    checks++; if (bus.out_data !== 32'hD1 || bus.out_queue !== 2'd3) begin fails++; $display("FAIL gap_beat1 got=%h/q%0d exp=d1/q3", bus.out_data, bus.out_queue); end
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 4'b1000) begin fails++; $display("FAIL gap_ready cycle=%0d got=%b exp=1000", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL gap_bubble cycle=%0d got=%b exp=0", i, bus.out_valid); end
    end
    bus.in_valid   = 4'b1001;
    bus.in_data[3] = 32'hD2;
    bus.in_last[3] = 1'b1;
    tick();
    checks++; if (bus.out_data !== 32'hD2 || bus.out_queue !== 2'd3 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL gap_last got=%h/q%0d/l%b exp=d2/q3/l1", bus.out_data, bus.out_queue, bus.out_last);
    end
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL gap_q0_ready got=%b exp=0001", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 32'hC0 || bus.out_queue !== 2'd0) begin fails++; $display("FAIL gap_q0_beat got=%h/q%0d exp=c0/q0", bus.out_data, bus.out_queue); end
    bus.in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    bus.out_ready  = 1'b1;
    bus.in_valid   = 4'b0010;
    bus.in_last    = 4'b0000;
    bus.in_data[1] = 32'hE0;
    tick();
    checks++; if (bus.out_data !== 32'hE0 || bus.out_queue !== 2'd1) begin fails++; $display("FAIL rstmid_beat0 got=%h/q%0d exp=e0/q1", bus.out_data, bus.out_queue); end
    bus.in_data[1] = 32'hE1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_in_ready got=%b exp=0000", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL rstmid_rr_ptr got=%0d exp=0", dut.rr_ptr_q); end
    rst_n          = 1'b1;
    bus.in_valid   = 4'b0011;
    bus.in_data[1] = 32'hE2;
    bus.in_data[0] = 32'hF0;
    bus.in_last[0] = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL rstmid_q0_ready got=%b exp=0001", bus.in_ready); end
    tick();
    checks++; if (bus.out_data !== 32'hF0 || bus.out_queue !== 2'd0 || bus.out_last !== 1'b1) begin
      fails++; $display("FAIL rstmid_q0_beat got=%h/q%0d/l%b exp=f0/q0/l1", bus.out_data, bus.out_queue, bus.out_last);
    end
    bus.in_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mid_packet_gap();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
